backward_layer: RTL and testbench

BACKWARD_LAYER -- requirements
Module: backward_layer

---
 rtl/backward_layer_pkg.sv | 32 +++
 rtl/backward_layer_if.sv | 27 ++
 rtl/backward_layer_sigmoid_deriv.sv | 28 ++
 rtl/backward_layer.sv | 143 ++++++++++++++
 tb/tb_backward_layer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/backward_layer_pkg.sv
// Shared types and fixed-point helpers for the forward/backward layer datapaths.
// Holds the FSM encoding, log2, the fixed-point ONE and the signed saturation bounds.
package backward_layer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ACCUM,
        ST_DERIV,
        ST_DONE
    } state_e;

    function automatic int log2_ceil(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int fx_one(input int frac);
        return 1 << frac;
    endfunction

    function automatic longint sat_hi(input int width);
        return (longint'(1) << (width - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int width);
        return -(longint'(1) << (width - 1));
    endfunction

endpackage

// File: rtl/backward_layer_if.sv
// Request/result bundle of the backward layer: operands in, propagated errors out.
interface backward_layer_if #(
    parameter int NUM_NEURON  = 5,
    parameter int DELTA_SIZE  = 18,
    parameter int WEIGHT_SIZE = 17,
    parameter int ACT_SIZE    = 9
);
    logic                                      start;
    logic [NUM_NEURON-1:0]                     active_in;
    logic [NUM_NEURON-1:0]                     active_out;
    logic [NUM_NEURON*DELTA_SIZE-1:0]          deltas;
    logic [NUM_NEURON*NUM_NEURON*WEIGHT_SIZE-1:0] weights;
    logic [NUM_NEURON*ACT_SIZE-1:0]            activations;
    logic [NUM_NEURON*DELTA_SIZE-1:0]          out_deltas;
    logic                                      out_valid;
    logic                                      busy;

    modport master (
        output start, active_in, active_out, deltas, weights, activations,
        input  out_deltas, out_valid, busy
    );

    modport slave (
        input  start, active_in, active_out, deltas, weights, activations,
        output out_deltas, out_valid, busy
    );
endinterface

// File: rtl/backward_layer_sigmoid_deriv.sv
// Sigmoid derivative a*(1-a) in unsigned fixed point; activations at or above ONE give 0.
module sigmoid_deriv
    import backward_layer_pkg::*;
#(
    parameter int ACT_SIZE     = 9,
    parameter int ACT_FRACTION = 8
) (
    input  logic [ACT_SIZE-1:0] a_i,
    output logic [ACT_SIZE-1:0] d_o
);
    localparam int                PW    = 2 * ACT_SIZE;
    localparam logic [ACT_SIZE-1:0] ONE_V = ACT_SIZE'(fx_one(ACT_FRACTION));

    logic [ACT_SIZE-1:0] compl_v;
    logic [PW-1:0]       prod;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        compl_v = '0;
        prod    = '0;
        d_o     = '0;
        if (a_i < ONE_V) begin
            compl_v = ONE_V - a_i;
            prod    = PW'(a_i) * PW'(compl_v);
            d_o     = ACT_SIZE'(prod >> ACT_FRACTION);
        end
    end
endmodule

// File: rtl/backward_layer.sv
// Transposed-weight error back-propagation: one MAC per input-side neuron, one
// upstream neuron per cycle, then derivative scaling and saturation.
module backward_layer
    import backward_layer_pkg::*;
#(
    parameter int NUM_NEURON      = 5,
    parameter int DELTA_SIZE      = 18,
    parameter int WEIGHT_SIZE     = 17,
    parameter int ACT_SIZE        = 9,
    parameter int DELTA_FRACTION  = 8,
    parameter int WEIGHT_FRACTION = 8,
    parameter int ACT_FRACTION    = 8
) (
    input logic             clk,
    input logic             rst,
    backward_layer_if.slave bus
);
    localparam int J_W    = (NUM_NEURON > 1) ? log2_ceil(NUM_NEURON) : 1;
    localparam int PROD_W = DELTA_SIZE + WEIGHT_SIZE;
    // Wide enough that a full column of max-magnitude products never wraps.
    localparam int ACC_W  = PROD_W - WEIGHT_FRACTION + log2_ceil(NUM_NEURON) + 1;
    localparam int RES_W  = ACC_W + ACT_SIZE + 1;
    localparam logic [J_W-1:0]              J_LAST = J_W'(NUM_NEURON - 1);
    localparam logic signed [DELTA_SIZE-1:0] SAT_HI = DELTA_SIZE'(sat_hi(DELTA_SIZE));
    localparam logic signed [DELTA_SIZE-1:0] SAT_LO = DELTA_SIZE'(sat_lo(DELTA_SIZE));

    state_e state_q, state_d;
    logic [J_W-1:0] j_q;

    logic signed [DELTA_SIZE-1:0]  delta_q  [NUM_NEURON];
    logic signed [WEIGHT_SIZE-1:0] weight_q [NUM_NEURON][NUM_NEURON];
    logic [ACT_SIZE-1:0]           act_q    [NUM_NEURON];
    logic [NUM_NEURON-1:0]         act_in_q, act_out_q;

    logic signed [ACC_W-1:0]       acc_q    [NUM_NEURON];
    logic signed [DELTA_SIZE-1:0]  out_q    [NUM_NEURON];

    logic signed [PROD_W-1:0]      prod     [NUM_NEURON];
    logic signed [ACC_W-1:0]       term     [NUM_NEURON];
    logic [ACT_SIZE-1:0]           deriv    [NUM_NEURON];
    logic signed [RES_W-1:0]       full     [NUM_NEURON];
    logic signed [RES_W-1:0]       shifted  [NUM_NEURON];
    logic signed [DELTA_SIZE-1:0]  sat_val  [NUM_NEURON];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_ACCUM;
            ST_ACCUM: if (j_q == J_LAST) state_d = ST_DERIV;
            ST_DERIV: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q != ST_IDLE);
        bus.out_valid = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            j_q <= '0;
        end else if (state_q == ST_LOAD) begin
            j_q <= '0;
        end else if (state_q == ST_ACCUM) begin
            j_q <= (j_q == J_LAST) ? '0 : j_q + 1'b1;
        end
    end

    // NOTE: operand storage is a plain register file with no reset; it is always written in LOAD before use.
    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD) begin
            for (int j = 0; j < NUM_NEURON; j++) begin
                delta_q[j] <= bus.deltas[j*DELTA_SIZE +: DELTA_SIZE];
                act_q[j]   <= bus.activations[j*ACT_SIZE +: ACT_SIZE];
                for (int i = 0; i < NUM_NEURON; i++)
                    weight_q[j][i] <= bus.weights[(j*NUM_NEURON+i)*WEIGHT_SIZE +: WEIGHT_SIZE];
            end
            act_in_q  <= bus.active_in;
            act_out_q <= bus.active_out;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_NEURON; i++) begin
            prod[i] = PROD_W'(weight_q[j_q][i]) * PROD_W'(delta_q[j_q]);
            term[i] = act_in_q[j_q] ? ACC_W'(prod[i] >>> WEIGHT_FRACTION) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_NEURON; i++) acc_q[i] <= '0;
        end else if (state_q == ST_LOAD) begin
            for (int i = 0; i < NUM_NEURON; i++) acc_q[i] <= '0;
        end else if (state_q == ST_ACCUM) begin
            for (int i = 0; i < NUM_NEURON; i++) acc_q[i] <= acc_q[i] + term[i];
        end
    end

    for (genvar i = 0; i < NUM_NEURON; i++) begin : g_deriv
        sigmoid_deriv #(
            .ACT_SIZE     (ACT_SIZE),
            .ACT_FRACTION (ACT_FRACTION)
        ) u_deriv (
            .a_i (act_q[i]),
            .d_o (deriv[i])
        );
    end

    // Saturate when the bits above the delta sign bit are not all copies of it.
    always_comb begin
        for (int i = 0; i < NUM_NEURON; i++) begin
            full[i]    = RES_W'(acc_q[i]) * RES_W'($signed({1'b0, deriv[i]}));
            shifted[i] = full[i] >>> ACT_FRACTION;
            if ((&shifted[i][RES_W-1:DELTA_SIZE-1]) || !(|shifted[i][RES_W-1:DELTA_SIZE-1]))
                sat_val[i] = shifted[i][DELTA_SIZE-1:0];
            else
                sat_val[i] = shifted[i][RES_W-1] ? SAT_LO : SAT_HI;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_NEURON; i++) out_q[i] <= '0;
        end else if (state_q == ST_DERIV) begin
            for (int i = 0; i < NUM_NEURON; i++) out_q[i] <= act_out_q[i] ? sat_val[i] : '0;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_NEURON; i++)
            bus.out_deltas[i*DELTA_SIZE +: DELTA_SIZE] = out_q[i];
    end
endmodule

// File: tb/tb_backward_layer.sv
// Scoreboard bench for backward_layer: directed steps push expected vectors,
// a negedge monitor pops and compares on every out_valid pulse.
module tb_backward_layer;
    localparam int N  = 5;
    localparam int DS = 18;
    localparam int WS = 17;
    localparam int AS = 9;

    logic clk = 1'b0;
    logic rst;

    backward_layer_if #(.NUM_NEURON(N), .DELTA_SIZE(DS), .WEIGHT_SIZE(WS), .ACT_SIZE(AS)) bus ();

    backward_layer #(
        .NUM_NEURON(N), .DELTA_SIZE(DS), .WEIGHT_SIZE(WS), .ACT_SIZE(AS),
        .DELTA_FRACTION(8), .WEIGHT_FRACTION(8), .ACT_FRACTION(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [N*DS-1:0] exp_q [$];

    logic signed [DS-1:0] dl [N];
    logic signed [WS-1:0] wt [N][N];
    logic [AS-1:0]        ac [N];

    task automatic check(input string name, input longint act, input longint exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [N*DS-1:0] pk(input longint e0, e1, e2, e3, e4);
        logic [N*DS-1:0] v;
        v[0*DS +: DS] = DS'(e0);
        v[1*DS +: DS] = DS'(e1);
        v[2*DS +: DS] = DS'(e2);
        v[3*DS +: DS] = DS'(e3);
        v[4*DS +: DS] = DS'(e4);
        return v;
    endfunction

    function automatic logic [N*DS-1:0] rep(input longint e);
        return pk(e, e, e, e, e);
    endfunction

    task automatic apply(input logic [N-1:0] ain, input logic [N-1:0] aout);
        for (int j = 0; j < N; j++) begin
            bus.deltas[j*DS +: DS]      = dl[j];
            bus.activations[j*AS +: AS] = ac[j];
            for (int i = 0; i < N; i++) bus.weights[(j*N+i)*WS +: WS] = wt[j][i];
        end
        bus.active_in  = ain;
        bus.active_out = aout;
    endtask

    task automatic set_uniform(input longint w, input longint d, input longint a,
                               input logic [N-1:0] ain, input logic [N-1:0] aout);
        for (int j = 0; j < N; j++) begin
            dl[j] = DS'(d);
            ac[j] = AS'(a);
            for (int i = 0; i < N; i++) wt[j][i] = WS'(w);
        end
        apply(ain, aout);
    endtask

    // One backward step; with disturb set, start is re-pulsed in ACCUM and DONE with new inputs.
    task automatic run_step(input logic [N*DS-1:0] expv, input bit disturb);
        int cyc;
        @(posedge clk); #1 bus.start = 1'b1;
        exp_q.push_back(expv);
        @(posedge clk); #1 bus.start = 1'b0;
        cyc = 1;
        check("busy_in_load", bus.busy, 1);
        while (bus.out_valid !== 1'b1 && cyc < 40) begin
            if (disturb && cyc == 3) begin
                set_uniform(65535, -131071, 128, '1, '1);
                bus.start = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
            if (disturb && cyc == 4) bus.start = 1'b0;
        end
        check("latency_cycles", cyc, N + 3);
        if (disturb) bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        check("busy_after_done", bus.busy, 0);
        @(posedge clk); #1;
        check("idle_next_cycle", bus.busy, 0);
    endtask

    initial begin : monitor
        logic [N*DS-1:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_out_valid: got pulse at %0t, expected none", $time);
                end else begin
                    e = exp_q.pop_front();
                    for (int i = 0; i < N; i++)
                        check($sformatf("out_delta[%0d]", i),
                              longint'($signed(bus.out_deltas[i*DS +: DS])),
                              longint'($signed(e[i*DS +: DS])));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst       = 1'b0;
        bus.start = 1'b0;
        set_uniform(0, 0, 0, '0, '0);
        #22;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_out_deltas_nonzero", longint'(|bus.out_deltas), 0);
        rst = 1'b1;

        set_uniform(256, 256, 128, '1, '1);
        run_step(rep(320), 1'b0);

        set_uniform(256, 256, 128, 5'b00001, '1);
        run_step(rep(64), 1'b0);

        set_uniform(256, 256, 128, '1, 5'b10101);
        run_step(pk(320, 0, 320, 0, 320), 1'b0);

        set_uniform(65535, 131071, 128, '1, '1);
        run_step(rep(131071), 1'b0);

        set_uniform(65535, -131071, 128, '1, '1);
        run_step(rep(-131072), 1'b0);

        set_uniform(256, 256, 0, '1, '1);
        ac[1] = 9'd256; ac[2] = 9'd128; ac[4] = 9'd256;
        apply('1, '1);
        run_step(pk(0, 0, 320, 0, 0), 1'b0);

        // W[j][i] nonzero only for i == j+1 (mod 5): out_i = delta_{i-1} / 4.
        for (int j = 0; j < N; j++)
            for (int i = 0; i < N; i++) wt[j][i] = (i == (j + 1) % N) ? 17'sd256 : 17'sd0;
        dl[0] = 18'sd256; dl[1] = 18'sd512; dl[2] = -18'sd768; dl[3] = 18'sd1024; dl[4] = -18'sd1280;
        for (int j = 0; j < N; j++) ac[j] = 9'd128;
        apply('1, '1);
        run_step(pk(-320, 64, 128, -192, 256), 1'b0);

        // Abort in ACCUM at j=2, then a clean step after release.
        set_uniform(256, 256, 128, '1, '1);
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_out_deltas_nonzero", longint'(|bus.out_deltas), 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (12) @(posedge clk);
        #1 check("post_abort_idle", bus.busy, 0);
        run_step(rep(320), 1'b0);

        set_uniform(256, 256, 128, '1, '1);
        run_step(rep(320), 1'b1);

        repeat (12) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
